ex_operand_stage: RTL
=====================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have decode inputs: id_valid 1; id_rs1_data 32; id_rs2_data 32; id_imm 32; id_pc 32; id_rs1 5; id_rs2 5; id_rd 5; id_uses_rs2 1; id_alu_op 4; id_alusrc_imm 1; id_srca_pc 1; id_regwrite 1; id_memread 1; id_memwrite 1.
REQ-004 SHALL have forwarding inputs: exmem_regwrite 1; exmem_rd 5; exmem_result 32; memwb_regwrite 1; memwb_rd 5; memwb_data 32.
REQ-005 SHALL have control inputs: ex_hold 1 (downstream stall, freeze stage); flush 1 (squash stage contents).
REQ-006 SHALL have ALU-facing outputs: SrcA 32; SrcB 32; Operation 4.
REQ-007 SHALL have other outputs: ex_valid 1; ex_rd 5; ex_regwrite 1; ex_memread 1; ex_memwrite 1; ex_store_data 32; hazard_stall 1 (to decode/fetch: hold ID).

Function
REQ-008 SHALL hold one ID/EX entry: valid, pc, imm, rs1/rs2 indices, rs1/rs2 operand values, rd, alu_op, alusrc_imm, srca_pc, regwrite, memread, memwrite.
REQ-009 SHALL update the entry per cycle with priority: reset > flush > ex_hold > hazard bubble > load.
REQ-010 Flush: entry becomes a bubble next cycle regardless of ex_hold.
REQ-011 Bubble: valid=0, regwrite=0, memread=0, memwrite=0, rd=0, alu_op=4'b0010 (ADD), all data fields 0.
REQ-012 ex_hold (no flush): entry retained except operand refresh per REQ-013.
REQ-013 Operand refresh while held: if memwb_regwrite, memwb_rd!=0 and memwb_rd equals stored rs1 (rs2), stored rs1 (rs2) value SHALL be replaced by memwb_data, so a producer retiring during the stall is not lost.
REQ-014 hazard_stall (combinational) SHALL equal ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-015 hazard_stall with no flush/ex_hold: bubble loaded; decode is responsible for holding the ID instruction, and it is reloaded the following cycle once hazard clears.
REQ-016 Load: when id_valid and none of the above, all decode fields captured; when id_valid=0, bubble loaded.
REQ-017 Forwarded rsN value (combinational, from stored entry): if exmem_regwrite & exmem_rd!=0 & exmem_rd==rsN -> exmem_result; else if memwb_regwrite & memwb_rd!=0 & memwb_rd==rsN -> memwb_data; else stored rsN value. EX/MEM SHALL win when both match.
REQ-018 Register x0 SHALL never be forwarded; rsN==0 always yields stored value.
REQ-019 SrcA SHALL be stored pc if srca_pc else forwarded rs1.
REQ-020 SrcB SHALL be stored imm if alusrc_imm else forwarded rs2.
REQ-021 ex_store_data SHALL always be forwarded rs2, independent of alusrc_imm.
REQ-022 Operation SHALL be stored alu_op passed unmodified; legal codes 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLL, 1000 SRL, 1001 SLT, 1010 SLTU, 1011 SRA; undefined codes passed through without checking.
REQ-023 ex_valid/ex_rd/ex_regwrite/ex_memread/ex_memwrite SHALL be the stored entry fields.
REQ-024 Latency SHALL be one cycle ID->EX; no internal arithmetic beyond equality compares and muxes; all widths exact, no extension.

Reset
REQ-025 reset SHALL load a bubble (REQ-011) on the next rising edge, overriding flush, ex_hold and any operand refresh.
REQ-026 After reset until first load: ex_valid=0, Operation=0010, SrcA=0, SrcB=0, ex_store_data=0, hazard_stall=0 (forwarding inputs inactive).
REQ-027 reset asserted mid-stall SHALL discard the held entry; no refreshed value survives.

Verification
REQ-028 ID add x3,x1,x2 (x1=4, x2=5), no forwarding -> next cycle SrcA=4, SrcB=5, Operation=0010, ex_rd=3, ex_valid=1.
REQ-029 Stage holds rs1=x1 (stored 4); exmem_regwrite=1, exmem_rd=1, exmem_result=0x11; memwb_regwrite=1, memwb_rd=1, memwb_data=0x22 -> SrcA=0x11; drop EX/MEM -> SrcA=0x22; rs1=x0 with both rd=0 -> stored value.
REQ-030 EX holds lw x5 (memread=1); ID sub x6,x5,x7 -> hazard_stall=1 same cycle, next cycle ex_valid=0, Operation=0010, ex_regwrite=0; ID with id_uses_rs2=0 and rs2=x5 only -> hazard_stall=0.
REQ-031 ex_hold=1 for 3 cycles, entry rs2=x7 stored 0; memwb writes x7=0xDEAD in cycle 2, then idle -> after hold, SrcB=0xDEAD (alusrc_imm=0), ex_store_data=0xDEAD.
REQ-032 flush and ex_hold asserted together with valid entry -> next cycle bubble; reset with flush and id_valid -> bubble, all outputs per REQ-026.
REQ-033 srca_pc=1, alusrc_imm=1, pc=0x100, imm=0xFFFFFFFC, Operation=0010 -> SrcA=0x100, SrcB=0xFFFFFFFC, ex_store_data still forwarded rs2.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with EX/MEM and MEM/WB forwarding, operand muxes and load-use hazard detect; in: decode fields, forwarding buses, ex_hold/flush; out: SrcA/SrcB/Operation, EX control, store data, hazard_stall
module ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs2,
  input  logic [3:0]  id_alu_op,
  input  logic        id_alusrc_imm,
  input  logic        id_srca_pc,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  input  logic        ex_hold,
  input  logic        flush,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [3:0]  Operation,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic [31:0] ex_store_data,
  output logic        hazard_stall
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alusrc_imm;
    logic        srca_pc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
  } entry_t;
  localparam entry_t bubble = '{alu_op: 4'b0010, default: '0};
  entry_t entry_q, entry_d, held, loaded;
  logic [31:0] rs1_fwd, rs2_fwd;
  always_comb begin
    held = entry_q;
    held.rs1_val = memwb_regwrite && |memwb_rd && memwb_rd == entry_q.rs1 ? memwb_data : entry_q.rs1_val;
    held.rs2_val = memwb_regwrite && |memwb_rd && memwb_rd == entry_q.rs2 ? memwb_data : entry_q.rs2_val;
    loaded = '{valid: 1'b1, pc: id_pc, imm: id_imm, rs1: id_rs1, rs2: id_rs2,
               rs1_val: id_rs1_data, rs2_val: id_rs2_data, rd: id_rd, alu_op: id_alu_op,
               alusrc_imm: id_alusrc_imm, srca_pc: id_srca_pc, regwrite: id_regwrite,
               memread: id_memread, memwrite: id_memwrite};
    hazard_stall = entry_q.valid && entry_q.memread && |entry_q.rd && id_valid &&
                   (entry_q.rd == id_rs1 || (id_uses_rs2 && entry_q.rd == id_rs2));
    entry_d = flush ? bubble : ex_hold ? held : hazard_stall || !id_valid ? bubble : loaded;
    rs1_fwd = exmem_regwrite && |exmem_rd && exmem_rd == entry_q.rs1 ? exmem_result :
              memwb_regwrite && |memwb_rd && memwb_rd == entry_q.rs1 ? memwb_data : entry_q.rs1_val;
    rs2_fwd = exmem_regwrite && |exmem_rd && exmem_rd == entry_q.rs2 ? exmem_result :
              memwb_regwrite && |memwb_rd && memwb_rd == entry_q.rs2 ? memwb_data : entry_q.rs2_val;
    SrcA = entry_q.srca_pc ? entry_q.pc : rs1_fwd;
    SrcB = entry_q.alusrc_imm ? entry_q.imm : rs2_fwd;
    ex_store_data = rs2_fwd;
    Operation = entry_q.alu_op;
    ex_valid = entry_q.valid;
    ex_rd = entry_q.rd;
    ex_regwrite = entry_q.regwrite;
    ex_memread = entry_q.memread;
    ex_memwrite = entry_q.memwrite;
  end
  always_ff @(posedge clk) entry_q <= reset ? bubble : entry_d;
endmodule
